// File: rtl/hostmsg_wr.sv
`default_nettype none
// ============================================================================
//  Module      : hostmsg_wr
//  Description : Host message writer. Collects bytes written by the host to
//                the MSGDATA ZXUNO register into a 16-byte buffer, terminated
//                by a NUL byte or by a full buffer, then holds the message
//                until the consumer acknowledges it. MSGSTAT reports status.
//  Revision    : 1.0 - initial release
// ============================================================================
module hostmsg_wr #(
  parameter logic [7:0] MSGDATA = 8'hFE,
  parameter logic [7:0] MSGSTAT = 8'hFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regwr,
  input  logic       zxuno_regrd,
  input  logic       regaddr_changed,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic [3:0] msg_rdaddr,
  output logic [7:0] msg_rddata,
  output logic       msg_valid,
  output logic [4:0] msg_len,
  input  logic       msg_ack
);

  logic [7:0] buf_mem [0:15];

  logic [4:0] widx_q, widx_d;
  logic       writing_q, writing_d;
  logic       overflow_q, overflow_d;
  logic       valid_q, valid_d;
  logic [4:0] len_q, len_d;
  logic       acc_prev_q, acc_prev_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rddata_q;

  logic       acc;
  logic       acc_start;
  logic       buf_we;

  // Next-state logic: access edge detection, capture, index advance, ack
  always_comb begin
    acc        = (zxuno_addr == MSGDATA) && zxuno_regwr;
    // acc_prev, not the writing flag, marks the first cycle so that a NUL
    // access (which leaves writing low) is never captured twice.
    acc_start  = acc && !acc_prev_q;
    widx_d     = widx_q;
    writing_d  = writing_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    len_d      = len_q;
    acc_prev_d = acc;
    buf_we     = 1'b0;
    dout_d     = {valid_q, overflow_q, writing_q, widx_q};

    if (msg_ack) begin
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      writing_d  = 1'b0;
      widx_d     = 5'd0;
    end else if (regaddr_changed && (zxuno_addr == MSGDATA) && !valid_q) begin
      widx_d    = 5'd0;
      writing_d = 1'b0;
    end else if (acc_start) begin
      if (valid_q) begin
        overflow_d = 1'b1;
      end else begin
        buf_we = 1'b1;
        if (din == 8'h00) begin
          // NUL terminates without being counted: widx does not advance
          valid_d = 1'b1;
          len_d   = widx_q;
        end else begin
          writing_d = 1'b1;
          if (widx_q == 5'd15) begin
            valid_d = 1'b1;
            len_d   = 5'd16;
          end
        end
      end
    end else if (writing_q && !acc) begin
      widx_d    = widx_q + 5'd1;
      writing_d = 1'b0;
    end
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q     <= 5'd0;
      writing_q  <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      len_q      <= 5'd0;
      acc_prev_q <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      widx_q     <= widx_d;
      writing_q  <= writing_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      len_q      <= len_d;
      acc_prev_q <= acc_prev_d;
      dout_q     <= dout_d;
    end
  end

  // Message buffer storage; contents are not reset
  always_ff @(posedge clk) begin
    if (buf_we && !rst) begin
      buf_mem[widx_q[3:0]] <= din;
    end
  end

  // Registered consumer read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rddata_q <= 8'h00;
    end else begin
      rddata_q <= buf_mem[msg_rdaddr];
    end
  end

  assign dout       = dout_q;
  assign msg_rddata = rddata_q;
  assign msg_valid  = valid_q;
  assign msg_len    = valid_q ? len_q : widx_q;
  assign oe_n       = !((zxuno_addr == MSGSTAT) && zxuno_regrd);

endmodule
`default_nettype wire

// File: doc/hostmsg_wr.md
HOSTMSG_WR -- requirements
Module: hostmsg_wr

Interface
REQ-001 SHALL have parameter MSGDATA, default 8'hFE, meaning the ZXUNO register address that accepts message bytes.
REQ-002 SHALL have parameter MSGSTAT, default 8'hFD, meaning the ZXUNO register address that returns message status.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port zxuno_addr  input  8  currently selected ZXUNO register.
REQ-006 SHALL have port zxuno_regwr  input  1  high while the host writes the selected register.
REQ-007 SHALL have port zxuno_regrd  input  1  high while the host reads the selected register.
REQ-008 SHALL have port regaddr_changed  input  1  one-cycle pulse when zxuno_addr is rewritten.
REQ-009 SHALL have port din  input  8  host write data.
REQ-010 SHALL have port dout  output  8  registered status byte.
REQ-011 SHALL have port oe_n  output  1  active-low, asserted combinationally when zxuno_addr==MSGSTAT and zxuno_regrd==1.
REQ-012 SHALL have port msg_rdaddr  input  4  consumer buffer read index.
REQ-013 SHALL have port msg_rddata  output  8  buffer byte at msg_rdaddr.
REQ-014 SHALL have port msg_valid  output  1  complete message available, buffer locked.
REQ-015 SHALL have port msg_len  output  5  stored byte count, 0..16.
REQ-016 SHALL have port msg_ack  input  1  consumer one-cycle pulse releasing the buffer.

Function
REQ-017 SHALL hold a 16x8 buffer, a 5-bit write index widx (0..16), a writing flag, and a sticky overflow flag.
REQ-018 SHALL define a write access as zxuno_addr==MSGDATA and zxuno_regwr==1 for one or more consecutive cycles.
REQ-019 SHALL capture din into buffer[widx] on the first cycle of a write access only (writing 0->1), when msg_valid==0.
REQ-020 SHALL increment widx on the first cycle after the access ends (writing 1->0), so an access held for N cycles advances widx exactly once.
REQ-021 SHALL set msg_valid when the captured byte is 8'h00 (msg_len = widx before increment, NUL not counted) or when the 16th byte is captured (msg_len=16).
REQ-022 SHALL, while msg_valid==1, ignore write accesses: no buffer change, no widx change, overflow set to 1.
REQ-023 SHALL, on regaddr_changed==1 with zxuno_addr==MSGDATA and msg_valid==0, set widx=0 and writing=0; buffer contents retained.
REQ-024 SHALL, on msg_ack==1, clear msg_valid, overflow, writing and widx to 0; msg_ack has priority over a simultaneous write access or regaddr_changed, and that write is dropped.
REQ-025 SHALL drive msg_len = widx while msg_valid==0 and the latched length while msg_valid==1.
REQ-026 SHALL register msg_rddata = buffer[msg_rdaddr] with one-cycle latency.
REQ-027 SHALL register dout every cycle as {msg_valid, overflow, writing, widx[4:0]}.
REQ-028 SHALL not respond to zxuno_regrd at MSGDATA (oe_n stays high) and SHALL ignore writes to MSGSTAT.

Reset
REQ-029 SHALL, while rst==1, force widx=0, writing=0, overflow=0, msg_valid=0, msg_len=0, dout=8'h00, msg_rddata=8'h00; buffer contents undefined.
REQ-030 SHALL, on reset asserted mid-access, abandon the partial message; first access after release writes buffer[0].

Verification
REQ-031 SHALL cover: write "HI",00 at MSGDATA, 3-cycle accesses -> msg_valid=1, msg_len=2, buffer[0..1]=48,49, status dout=8'h82.
REQ-032 SHALL cover: 16 writes of 8'h41..8'h50 -> msg_valid=1, msg_len=16; 17th write -> buffer unchanged, dout=8'hD0.
REQ-033 SHALL cover: 3 bytes written, regaddr_changed at MSGDATA, write 8'h5A -> buffer[0]=8'h5A, widx=1.
REQ-034 SHALL cover: msg_ack in same cycle as write start while valid -> msg_valid=0, widx=0, overflow=0, byte not stored.
REQ-035 SHALL cover: rst pulse during 2nd write access -> all outputs 0; next write lands in buffer[0].
REQ-036 SHALL cover: msg_rdaddr=1 after REQ-031 -> msg_rddata=8'h49 one cycle later; read at MSGDATA -> oe_n=1.
